// File: rtl/riscv_core_lsu_pkg.sv
// Shared load/store unit types: access sizes, load-align FSM states and the
// byte-count helper used by the merge datapath and the split decision.
package riscv_core_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } ld_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_RESP
  } ld_state_e;

  function automatic logic [3:0] bytes_of(input ld_size_e size);
    case (size)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/riscv_core_ldalign_if.sv
// Load request, data bus and writeback signals of the load alignment unit.
// Signal prefixes are from the unit's point of view (i_ = into the unit).
interface riscv_core_ldalign_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              i_ld_valid;
  logic              o_ld_ready;
  logic [ADDR_W-1:0] i_ld_addr;
  logic [1:0]        i_ld_size;
  logic              i_ld_su_extend;
  logic [4:0]        i_ld_rd;

  logic              o_mem_req;
  logic              i_mem_gnt;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_rvalid;
  logic [XLEN-1:0]   i_mem_rdata;
  logic              i_mem_err;

  logic              o_wb_valid;
  logic              i_wb_ready;
  logic [XLEN-1:0]   o_wb_rdata;
  logic [4:0]        o_wb_rd;
  logic              o_wb_err;

  modport slave (
    input  i_ld_valid, i_ld_addr, i_ld_size, i_ld_su_extend, i_ld_rd,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_mem_err, i_wb_ready,
    output o_ld_ready, o_mem_req, o_mem_addr, o_wb_valid, o_wb_rdata, o_wb_rd, o_wb_err
  );

  modport master (
    output i_ld_valid, i_ld_addr, i_ld_size, i_ld_su_extend, i_ld_rd,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata, i_mem_err, i_wb_ready,
    input  o_ld_ready, o_mem_req, o_mem_addr, o_wb_valid, o_wb_rdata, o_wb_rd, o_wb_err
  );

endinterface

// File: rtl/riscv_core_ldalign_merge.sv
// Combinational merge of two bus beats: shift the addressed bytes down to
// bit 0, keep bytes_of(size) bytes and sign- or zero-extend to XLEN.
module riscv_core_ldalign_merge
  import riscv_core_lsu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int OFF_W = $clog2(XLEN / 8),
  localparam int IDX_W = $clog2(2 * XLEN)
) (
  input  logic [XLEN-1:0]  beat0_i,
  input  logic [XLEN-1:0]  beat1_i,
  input  logic [OFF_W-1:0] off_i,
  input  ld_size_e         size_i,
  input  logic             su_extend_i,
  output logic [XLEN-1:0]  result_o
);

  logic [2*XLEN-1:0] shifted;
  logic [6:0]        nbits;
  logic [IDX_W-1:0]  msb_idx;
  logic [XLEN-1:0]   keep;
  logic              fill;

  always_comb begin
    shifted  = {beat1_i, beat0_i} >> {off_i, 3'b000};
    nbits    = {bytes_of(size_i), 3'b000};
    msb_idx  = IDX_W'(nbits - 7'd1);
    fill     = ~su_extend_i & shifted[msb_idx];
    // A full-width access shifts every bit out, leaving an all-ones mask.
    keep     = ~({XLEN{1'b1}} << nbits);
    result_o = (shifted[XLEN-1:0] & keep) | ({XLEN{fill}} & ~keep);
  end

endmodule

// File: rtl/riscv_core_ldalign.sv
// Load alignment unit: issues one or two aligned bus reads per load, merges
// the beats and holds the extended result for writeback.
module riscv_core_ldalign
  import riscv_core_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  riscv_core_ldalign_if.slave bus
);

  localparam int                NB    = XLEN / 8;
  localparam int                OFF_W = $clog2(NB);
  localparam logic [ADDR_W-1:0] NB_A  = ADDR_W'(NB);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  ld_size_e          size_q, size_d;
  logic              su_q, su_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   beat0_q, beat0_d;
  logic [XLEN-1:0]   beat1_q, beat1_d;
  logic              err_q, err_d;

  logic [OFF_W-1:0]  off;
  logic [ADDR_W-1:0] aligned;
  logic              misaligned;
  logic              illegal_req;
  logic              in_resp;
  logic [XLEN-1:0]   merged;

  assign off         = addr_q[OFF_W-1:0];
  assign aligned     = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign misaligned  = (int'(off) + int'(bytes_of(size_q))) > NB;
  assign illegal_req = (XLEN == 32) && (ld_size_e'(bus.i_ld_size) == SZ_D);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    su_d    = su_q;
    rd_d    = rd_q;
    beat0_d = beat0_q;
    beat1_d = beat1_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_ld_valid) begin
          addr_d  = bus.i_ld_addr;
          size_d  = ld_size_e'(bus.i_ld_size);
          su_d    = bus.i_ld_su_extend;
          rd_d    = bus.i_ld_rd;
          err_d   = illegal_req;
          state_d = illegal_req ? ST_RESP : ST_REQ0;
        end
      end
      ST_REQ0: if (bus.i_mem_gnt) state_d = ST_WAIT0;
      ST_WAIT0: begin
        if (bus.i_mem_rvalid) begin
          beat0_d = bus.i_mem_rdata;
          // A faulting first beat never triggers the second read.
          if (bus.i_mem_err) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = misaligned ? ST_REQ1 : ST_RESP;
          end
        end
      end
      ST_REQ1: if (bus.i_mem_gnt) state_d = ST_WAIT1;
      ST_WAIT1: begin
        if (bus.i_mem_rvalid) begin
          beat1_d = bus.i_mem_rdata;
          err_d   = err_q | bus.i_mem_err;
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (bus.i_wb_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: the beat registers are plain flops, so they are reset with the
    // rest of the state and no stale bus data survives a reset.
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= SZ_B;
      su_q    <= 1'b0;
      rd_q    <= '0;
      beat0_q <= '0;
      beat1_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      su_q    <= su_d;
      rd_q    <= rd_d;
      beat0_q <= beat0_d;
      beat1_q <= beat1_d;
      err_q   <= err_d;
    end
  end

  riscv_core_ldalign_merge #(.XLEN(XLEN)) u_merge (
    .beat0_i     (beat0_q),
    .beat1_i     (beat1_q),
    .off_i       (off),
    .size_i      (size_q),
    .su_extend_i (su_q),
    .result_o    (merged)
  );

  // Outputs decode only registered state, never the bus inputs.
  assign in_resp        = (state_q == ST_RESP);
  assign bus.o_ld_ready = i_rst_n & (state_q == ST_IDLE);
  assign bus.o_mem_req  = (state_q == ST_REQ0) | (state_q == ST_REQ1);
  assign bus.o_wb_valid = in_resp;
  assign bus.o_wb_rdata = (in_resp && !err_q) ? merged : '0;
  assign bus.o_wb_rd    = in_resp ? rd_q : '0;
  assign bus.o_wb_err   = in_resp & err_q;

  always_comb begin
    bus.o_mem_addr = '0;
    if (state_q == ST_REQ0) bus.o_mem_addr = aligned;
    if (state_q == ST_REQ1) bus.o_mem_addr = aligned + NB_A;
  end

endmodule

// File: doc/riscv_core_ldalign.md
# riscv_core_ldalign

Parametrised load alignment unit for the RV32IMC/RV64 memory stage. Accepts one load request at a time from the pipeline and issues one or two aligned bus reads, splitting a misaligned access across two words. It merges the returned beats, shifts the addressed bytes to bit 0, and applies sign/zero extension. It then holds the result for writeback under a valid/ready handshake.

## Interface
Parameters:
- XLEN, 32, data/bus width in bits; 32 or 64.
- ADDR_W, 32, address width.

Ports (clock and reset first):
- i_clk  in  1  core clock; one clock domain.
- i_rst_n  in  1  synchronous, active-low reset.
- i_ld_valid  in  1  load request valid.
- o_ld_ready  out  1  request accepted when i_ld_valid & o_ld_ready.
- i_ld_addr  in  ADDR_W  byte address.
- i_ld_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- i_ld_su_extend  in  1  0 = sign-extend, 1 = zero-extend.
- i_ld_rd  in  5  destination tag, returned unchanged.
- o_mem_req  out  1  bus read request.
- i_mem_gnt  in  1  request accepted this cycle.
- o_mem_addr  out  ADDR_W  word-aligned address: low log2(XLEN/8) bits are 0.
- i_mem_rvalid  in  1  read data valid; earliest one cycle after gnt.
- i_mem_rdata  in  XLEN  read data.
- i_mem_err  in  1  bus error, qualified by i_mem_rvalid.
- o_wb_valid  out  1  result valid.
- i_wb_ready  in  1  writeback accepts result.
- o_wb_rdata  out  XLEN  extended load data.
- o_wb_rd  out  5  tag of the result.
- o_wb_err  out  1  load faulted.

## Operation
- NB = XLEN/8 and off = addr mod NB. The access is misaligned when off + bytes(size) > NB.
- FSM states are IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: o_ld_ready=1. On accept, register addr, size, su_extend and rd, then go to REQ0.
- Illegal size: size 11 with XLEN=32 goes directly to RESP with err=1. No bus access is made.
- REQ0: o_mem_req=1 with o_mem_addr = addr with the low bits cleared. Hold the request until i_mem_gnt, then go to WAIT0.
- WAIT0: on rvalid, capture beat0.
  - If err: go to RESP with err=1.
  - Else if misaligned: go to REQ1.
  - Else: go to RESP.
- REQ1/WAIT1: same as REQ0/WAIT0, with o_mem_addr = aligned + NB. On rvalid, capture beat1 and OR its error into err, then go to RESP.
- Merge: take the 2·XLEN value {beat1, beat0} and shift it right by off·8. Keep the low bytes(size) bytes.
- Extension: bit (8·bytes−1) is replicated when su_extend=0; zeros are inserted when su_extend=1.
- When err=1, o_wb_rdata=0.
- RESP: o_wb_valid=1 and all wb outputs stay stable until i_wb_ready, then go to IDLE.
- o_ld_ready=0 outside IDLE. There is no pipelining of a second request.
- i_mem_rvalid is ignored in IDLE, REQ0 and REQ1. i_mem_gnt is ignored outside REQ states.

## Timing
- Reset values: o_ld_ready=0 during reset, 1 in the first cycle after reset.
- All other outputs reset to 0: o_mem_req, o_mem_addr, o_wb_valid, o_wb_rdata, o_wb_rd, o_wb_err. The state resets to IDLE.
- All outputs are registered or decoded from the state only. There is no combinational path from i_mem_* to o_wb_*.
- Aligned, zero-wait case:
  - Accept at T.
  - o_mem_req at T+1, with gnt at T+1.
  - rvalid at T+2.
  - o_wb_valid at T+3.
- Misaligned case: 2 cycles more than aligned, so o_wb_valid at T+5 with zero-wait bus.
- Back-to-back: a new request can be accepted the cycle after the RESP handshake.
- Reset mid-operation: the next cycle is IDLE with reset outputs. The pending bus beat is dropped.

## Structure
- The shared package riscv_core_lsu_pkg holds:
  - the size enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - the state enum;
  - the function bytes_of(size).
- Sub-module riscv_core_ldalign_merge is purely combinational. It covers merge, shift and extend.
  - Inputs: beat0, beat1, off, size, su_extend.
  - Output: XLEN result.
  - It is unit-testable on its own.

## Test plan
- LB at 0x1003, word 0x80112233: su=0 → 0xFFFFFF80; su=1 → 0x00000080. One request at 0x1000.
- LW at 0x2002, words 0xDDCCBBAA @0x2000 and 0x44332211 @0x2004 → 0x2211DDCC. Two requests in order, o_mem_addr 0x2000 then 0x2004.
- LH at 0x2003 with the same memory → 0x000011DD for su=0; LH at 0x2001 → 0xFFFFCCBB.
- Bus stalls: gnt delayed 2 cycles and rvalid 3 cycles → o_mem_req and addr held steady; no second request before the first rvalid. With i_wb_ready low 4 cycles → wb outputs stable and o_ld_ready=0.
- Error handling:
  - Misaligned LW with i_mem_err on beat0 → no request to +4; o_wb_err=1, rdata=0.
  - size 11 at XLEN=32 → o_wb_err=1 with no o_mem_req.
- Reset asserted in WAIT1 → next cycle IDLE with all outputs at reset values. A late rvalid is ignored. The next LW at 0x3000 completes correctly.
